// File: rtl/shift_mix_stage.sv
// AES round stage after SubBytes: ShiftRows, then column-serial MixColumns.
// MixColumns is skipped on the final round; result held under valid/ready.
module shift_mix_stage #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         last_round,
  input  logic [0:127] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] block_out,
  output logic         busy
);

  localparam int NMIX = 4 / COLS_PER_CYCLE;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MIX,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   col_cnt;
  logic         last_q;
  logic [0:127] work;
  logic [0:127] work_mix;
  logic [1:0]   col;
  logic         mix_end;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  // byte (r,c) sits at index 4c+r; row r rotates left by r columns
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == LOAD) || (state == MIX);
  assign mix_end   = (col_cnt == 2'(NMIX - 1));

  // mix the column group selected by col_cnt, leave the rest untouched
  always_comb begin
    work_mix = work;
    col      = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col = 2'(int'(col_cnt) * COLS_PER_CYCLE + j);
      work_mix[32*col +: 32] = mix_col(work[32*col +: 32]);
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      LOAD: state_nxt = last_q ? DONE : MIX;
      MIX:  if (mix_end) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // working register, column counter and held result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work      <= '0;
      block_out <= '0;
      col_cnt   <= '0;
      last_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= shift_rows(block_in);
            last_q <= last_round;
          end
        end
        LOAD: begin
          col_cnt <= '0;
          if (last_q) block_out <= work;
        end
        MIX: begin
          work <= work_mix;
          if (mix_end) block_out <= work_mix;
          else         col_cnt   <= col_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mix_stage.sv
// Bench for shift_mix_stage: three widths driven from one scoreboard,
// FIPS-197 vectors, corner columns, backpressure, reset and streaming.
module tb_shift_mix_stage;

  logic         clock = 1'b0;
  logic         reset;
  logic         iv[3];
  logic         lr[3];
  logic         ordy[3];
  logic         ir[3];
  logic         ov[3];
  logic         bsy[3];
  logic [0:127] bin[3];
  logic [0:127] bout[3];
  logic         prev[3];

  typedef struct {
    logic [0:127] data;
    int           due;
  } exp_t;

  exp_t q[3][$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  shift_mix_stage #(.COLS_PER_CYCLE(1)) u_d1 (
    .clock(clock), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .last_round(lr[0]), .block_in(bin[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .block_out(bout[0]), .busy(bsy[0])
  );

  shift_mix_stage #(.COLS_PER_CYCLE(2)) u_d2 (
    .clock(clock), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .last_round(lr[1]), .block_in(bin[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .block_out(bout[1]), .busy(bsy[1])
  );

  shift_mix_stage #(.COLS_PER_CYCLE(4)) u_d4 (
    .clock(clock), .reset(reset),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .last_round(lr[2]), .block_in(bin[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .block_out(bout[2]), .busy(bsy[2])
  );

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int nmix(int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_round(logic [0:127] x,
                                             logic last);
    logic [7:0]   s[4][4];
    logic [7:0]   t[4];
    logic [0:127] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = x[8*(4*((c+r)%4)+r) +: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++)
          t[r] = gmul(s[r][c], 8'd2) ^ gmul(s[(r+1)%4][c], 8'd3)
               ^ s[(r+2)%4][c] ^ s[(r+3)%4][c];
        for (int r = 0; r < 4; r++) s[r][c] = t[r];
      end
    end
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[8*(4*c+r) +: 8] = s[r][c];
    return y;
  endfunction

  function automatic logic [0:127] inv_sr(logic [0:127] s);
    logic [0:127] y;
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[8*(4*((c+r)%4)+r) +: 8] = s[8*(4*c+r) +: 8];
    return y;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(int k, logic [0:127] want, int due);
    exp_t e;
    e.data = want;
    e.due  = due;
    q[k].push_back(e);
  endtask

  task automatic send(int k, logic [0:127] blk, logic last,
                      logic [0:127] want);
    int n = 0;
    @(negedge clock);
    while (!ir[k] && n < 50) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("rdy%0d", k), ir[k], 1);
    iv[k]  = 1'b1;
    bin[k] = blk;
    lr[k]  = last;
    push(k, want, cyc + 2 + (last ? 0 : nmix(k)));
    @(negedge clock);
    iv[k]  = 1'b0;
    bin[k] = rnd128();
    lr[k]  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(int k);
    int n = 0;
    while (q[k].size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("drain%0d", k), q[k].size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        prev[k] = 1'b0;
      end else begin
        if (ov[k] && !prev[k] && q[k].size() > 0)
          check($sformatf("lat%0d", k), cyc, q[k][0].due);
        if (ov[k] && ordy[k]) begin
          if (q[k].size() == 0) begin
            check($sformatf("extra%0d", k), q[k].size(), 1);
          end else begin
            e = q[k].pop_front();
            check($sformatf("data%0d", k), bout[k], e.data);
          end
        end
        prev[k] = ov[k];
      end
    end
  end

  initial begin
    logic [0:127] blk;
    logic [0:127] want;
    int           n;
    int           caps;
    int           lastc;

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      lr[k]   = 1'b0;
      ordy[k] = 1'b1;
      bin[k]  = '0;
      prev[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", ir[k], 1);
      check("rst_out_valid", ov[k], 0);
      check("rst_block_out", bout[k], 0);
      check("rst_busy", bsy[k], 0);
    end
    @(negedge clock);
    reset = 1'b0;

    blk = 128'hd42711aee0bf98f1b8b45de51e415230;
    send(0, blk, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
    drain(0);
    send(0, blk, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    drain(0);

    blk = inv_sr(128'hdb135345f20a225c01010101c6c6c6c6);
    for (int k = 0; k < 3; k++) begin
      send(k, blk, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
      drain(k);
    end

    ordy[0] = 1'b0;
    blk  = rnd128();
    want = ref_round(blk, 1'b0);
    send(0, blk, 1'b0, want);
    n = 0;
    while (!ov[0] && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("bp_out_valid", ov[0], 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      iv[0]  = 1'($urandom_range(0, 1));
      bin[0] = rnd128();
      lr[0]  = 1'($urandom_range(0, 1));
      #1;
      check("bp_hold", bout[0], want);
      check("bp_in_ready", ir[0], 0);
    end
    @(negedge clock);
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clock);
    check("bp_release", ir[0], 1);
    blk = rnd128();
    send(0, blk, 1'b0, ref_round(blk, 1'b0));
    drain(0);

    blk = rnd128();
    send(0, blk, 1'b0, ref_round(blk, 1'b0));
    @(posedge clock);
    @(posedge clock);
    #2;
    check("mid_busy", bsy[0], 1);
    reset = 1'b1;
    #1;
    check("mid_out_valid", ov[0], 0);
    check("mid_block_out", bout[0], 0);
    check("mid_in_ready", ir[0], 1);
    q[0].delete();
    @(negedge clock);
    reset = 1'b0;
    blk = rnd128();
    send(0, blk, 1'b0, ref_round(blk, 1'b0));
    drain(0);

    for (int k = 0; k < 3; k++) begin
      caps  = 0;
      lastc = -1;
      n     = 0;
      ordy[k] = 1'b1;
      while (caps < 6 && n < 200) begin
        @(negedge clock);
        n++;
        iv[k]  = 1'b1;
        lr[k]  = 1'b0;
        bin[k] = rnd128();
        if (ir[k]) begin
          push(k, ref_round(bin[k], 1'b0), cyc + 2 + nmix(k));
          if (lastc >= 0)
            check($sformatf("gap%0d", k), cyc - lastc, 3 + nmix(k));
          lastc = cyc;
          caps++;
        end
      end
      check($sformatf("caps%0d", k), caps, 6);
      @(negedge clock);
      iv[k] = 1'b0;
      drain(k);
    end

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
